// File: rtl/fetch_prefetch.sv
// fetch_prefetch: sequential PC generator with handshaked imem requests and a
// credit-limited prefetch queue feeding decode; redirects flush and squash in-flight words.
module fetch_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_inst,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              misalign
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] fetch_pc, resp_pc, q_pc [DEPTH];
  logic [31:0]       q_inst [DEPTH];
  logic [CW-1:0]     count, outstanding, discard_cnt;
  logic [PW-1:0]     head, tail;
  logic              issue, keep, pop;
  assign imem_req  = !rst && !redirect_valid && (count + outstanding) < CW'(DEPTH) && outstanding < CW'(MAX_OUT);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;
  assign keep      = imem_rvalid && discard_cnt == '0 && !redirect_valid;
  assign dec_valid = count != '0;
  assign pop       = dec_valid && dec_ready && !redirect_valid;
  assign dec_inst  = q_inst[head];
  assign dec_pc    = q_pc[head];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      head        <= '0;
      tail        <= '0;
      misalign    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= RESET_PC;
      end
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
      misalign    <= redirect_valid && |redirect_pc[1:0];
      if (redirect_valid) begin
        // everything still in flight after this cycle belongs to the old path
        fetch_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
        resp_pc     <= {redirect_pc[ADDR_W-1:2], 2'b00};
        count       <= '0;
        tail        <= head;
        discard_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (issue) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (imem_rvalid && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
        if (keep) begin
          q_inst[tail] <= imem_rdata;
          q_pc[tail]   <= resp_pc;
          tail         <= tail + PW'(1);
          resp_pc      <= resp_pc + ADDR_W'(4);
        end
        if (pop) head <= head + PW'(1);
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: randomized and directed checks of fetch_prefetch against a
// queue-based model of in-flight requests and buffered instructions.
module tb_fetch_prefetch;
  logic clk = 0, rst = 0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0, redirect_valid = 0;
  logic dec_valid, dec_ready = 0, misalign;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, dec_inst, dec_pc;

  fetch_prefetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; bit stale; int due;} fl_t;
  typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;
  fl_t  inflight[$];
  ent_t q[$];
  logic [31:0] m_fetch, req_log[$], acc_log[$];
  int acc_cyc[$];
  bit m_mis, rv_rand, mis_seen;
  int cyc, n_cmp, n_bad;

  function automatic logic [31:0] hash(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; dec_ready = 0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", dec_valid, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_inst", dec_inst, 0);
    chk("rst_pc", dec_pc, 32'h3000);
    @(negedge clk);
    rst = 0;
    q.delete(); inflight.delete(); req_log.delete(); acc_log.delete(); acc_cyc.delete();
    m_fetch = 32'h3000; m_mis = 0; cyc = 0;
  endtask

  task automatic step(bit g, bit rdy, bit rd, logic [31:0] tgt, int lat);
    bit rv, exp_req, pop;
    fl_t f;
    @(negedge clk);
    imem_gnt = g; dec_ready = rdy; redirect_valid = rd; redirect_pc = tgt;
    rv = inflight.size() > 0 && inflight[0].due <= cyc && (!rv_rand || $urandom_range(1) == 1);
    imem_rvalid = rv;
    imem_rdata = rv ? hash(inflight[0].addr) : $urandom;
    #1;
    exp_req = !rd && (q.size() + inflight.size()) < 4 && inflight.size() < 2;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_fetch);
    chk("dec_valid", dec_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("dec_pc", dec_pc, q[0].pc);
      chk("dec_inst", dec_inst, q[0].inst);
    end
    chk("misalign", misalign, m_mis);
    mis_seen = misalign;
    if (imem_req && g) req_log.push_back(imem_addr);
    if (dec_valid && rdy && !rd) begin acc_log.push_back(dec_pc); acc_cyc.push_back(cyc); end
    m_mis = rd && |tgt[1:0];
    pop = q.size() > 0 && rdy && !rd;
    if (rd) begin
      q.delete();
      foreach (inflight[i]) inflight[i].stale = 1;
      if (rv) void'(inflight.pop_front());
      m_fetch = {tgt[31:2], 2'b00};
    end else begin
      if (pop) void'(q.pop_front());
      if (rv) begin
        f = inflight.pop_front();
        if (!f.stale) q.push_back('{inst: hash(f.addr), pc: f.addr});
      end
    end
    if (imem_req && g) inflight.push_back('{addr: imem_addr, stale: 0, due: cyc + lat});
    if (exp_req && g) m_fetch += 4;
    if (q.size() + inflight.size() > 4) chk("credit", q.size() + inflight.size(), 4);
    cyc++;
  endtask

  initial begin
    bit ok;
    rv_rand = 0;
    // 1: streaming with 1-cycle memory
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 1);
    chk("t1_addr0", req_log[0], 32'h3000);
    chk("t1_addr1", req_log[1], 32'h3004);
    chk("t1_addr2", req_log[2], 32'h3008);
    chk("t1_first_pc", acc_log[0], 32'h3000);
    chk("t1_first_cyc", acc_cyc[0], 2);
    chk("t1_second_cyc", acc_cyc[1], 3);
    // 2: decode stall fills to the credit limit, then drains in order
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1);
    chk("t2_reqs", req_log.size(), 4);
    chk("t2_head", dec_pc, 32'h3000);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) chk("t2_drain", acc_log[i], 32'h3000 + 4 * i);
    // 3: redirect with two requests outstanding on a 3-cycle memory
    do_reset();
    step(1, 1, 0, 0, 3);
    step(1, 1, 0, 0, 3);
    step(1, 1, 1, 32'h4000, 3);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0, 3);
    chk("t3_first", acc_log[0], 32'h4000);
    ok = 1;
    foreach (acc_log[i]) if (acc_log[i][31:12] == 20'h3) ok = 0;
    chk("t3_no_stale", ok, 1);
    // 4: redirect coincides with a response and a ready decode
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    step(1, 1, 1, 32'h5000, 1);
    step(1, 1, 0, 0, 1);
    chk("t4_empty", dec_valid, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
    chk("t4_first", acc_log[0], 32'h5000);
    // 5: misaligned target
    do_reset();
    step(1, 1, 0, 0, 1);
    step(1, 1, 1, 32'h4006, 1);
    step(1, 1, 0, 0, 1);
    chk("t5_mis_hi", mis_seen, 1);
    step(1, 1, 0, 0, 1);
    chk("t5_mis_lo", mis_seen, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
    chk("t5_first", acc_log[0], 32'h4004);
    // 6: random traffic with redirects and one mid-run reset
    rv_rand = 1;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] tgt;
      bit rd;
      if (n == 5000) do_reset();
      rd = $urandom_range(0, 99) < 4;
      tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rd, tgt, $urandom_range(1, 4));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
